// File: rtl/tag_pkg.sv
// tag_pkg: mode encodings and the buffered-entry layout shared by target_addr_gen.
`default_nettype none

package tag_pkg;

  localparam logic [1:0] MODE_JUMP   = 2'b00;
  localparam logic [1:0] MODE_BRANCH = 2'b01;
  localparam logic [1:0] MODE_REG    = 2'b10;
  localparam logic [1:0] MODE_SEQ    = 2'b11;

  // Widest address any instance may use; narrower instances zero-fill the top.
  localparam int TAG_MAX_ADDR_W = 64;

  typedef struct packed {
    logic [TAG_MAX_ADDR_W-1:0] target;
    logic                      misaligned;
  } tag_entry_t;

endpackage

`default_nettype wire

// File: rtl/tag_skid_buf.sv
// tag_skid_buf: 2-entry valid/ready skid buffer (output register + skid register).
// Revision: 1.0
`default_nettype none

module tag_skid_buf #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             w_accept;

  assign w_accept = in_valid_i && in_ready_o;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready_i) begin
      // Output slot frees up: older skid entry goes first; skid full implies no accept.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = w_accept;
        if (w_accept) begin
          out_d = in_data_i;
        end
      end
    end else if (w_accept) begin
      skid_d       = in_data_i;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready_o  = !skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_q;

endmodule

`default_nettype wire

// File: rtl/target_addr_gen.sv
// target_addr_gen: pipelined next-PC target generator (jump/branch/register/sequential).
// Optional macro TAG_BRANCH_EN enables the branch-offset adder; otherwise mode 01 acts as sequential.
`default_nettype none

module target_addr_gen
  import tag_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 26,
  parameter int OFF_W  = 16,
  parameter int SHIFT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] pc,
  input  logic [IDX_W-1:0]  idx,
  input  logic [OFF_W-1:0]  off,
  input  logic [ADDR_W-1:0] rs_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] target,
  output logic              misaligned
);

  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1} << SHIFT;

  logic [ADDR_W-1:0] w_pc4;
  logic [ADDR_W-1:0] w_jump;
  logic [ADDR_W-1:0] w_branch;
  logic              w_rs_mis;
  tag_entry_t        w_entry;
  logic [ADDR_W:0]   w_in_data;
  logic [ADDR_W:0]   w_out_data;

  assign w_pc4 = pc + PC_STEP;

  generate
    if (ADDR_W > IDX_W + SHIFT) begin : g_jump_hi
      assign w_jump = {w_pc4[ADDR_W-1:IDX_W+SHIFT], {(IDX_W+SHIFT){1'b0}}}
                    | (ADDR_W'(idx) << SHIFT);
    end else begin : g_jump_nohi
      assign w_jump = ADDR_W'(idx) << SHIFT;
    end

    if (SHIFT > 0) begin : g_mis
      assign w_rs_mis = |rs_val[SHIFT-1:0];
    end else begin : g_nomis
      assign w_rs_mis = 1'b0;
    end
  endgenerate

`ifdef TAG_BRANCH_EN
  assign w_branch = w_pc4 + (ADDR_W'($signed(off)) << SHIFT);
`else
  logic w_unused_off;
  assign w_unused_off = ^off;
  assign w_branch     = w_pc4;
`endif

  always_comb begin
    w_entry = '0;
    case (mode)
      MODE_JUMP:   w_entry.target = TAG_MAX_ADDR_W'(w_jump);
      MODE_BRANCH: w_entry.target = TAG_MAX_ADDR_W'(w_branch);
      MODE_REG: begin
        w_entry.target     = TAG_MAX_ADDR_W'(rs_val);
        w_entry.misaligned = w_rs_mis;
      end
      default:     w_entry.target = TAG_MAX_ADDR_W'(w_pc4);
    endcase
  end

  // Only ADDR_W target bits are stored; the zero padding above them is dropped here.
  assign w_in_data = {w_entry.misaligned, w_entry.target[ADDR_W-1:0]};

  generate
    if (ADDR_W < TAG_MAX_ADDR_W) begin : g_pad
      logic w_unused_pad;
      assign w_unused_pad = |w_entry.target[TAG_MAX_ADDR_W-1:ADDR_W];
    end
  endgenerate

  tag_skid_buf #(
    .WIDTH (ADDR_W + 1)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (w_in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (w_out_data)
  );

  assign target     = w_out_data[ADDR_W-1:0];
  assign misaligned = w_out_data[ADDR_W];

endmodule

`default_nettype wire

// File: tb/tb_target_addr_gen.sv
// tb_target_addr_gen: directed self-checking bench for target_addr_gen (default parameters).
`default_nettype none

module tb_target_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  mode = 2'b00;
  logic [31:0] pc = '0;
  logic [25:0] idx = '0;
  logic [15:0] off = '0;
  logic [31:0] rs_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] target;
  logic        misaligned;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  target_addr_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mode       (mode),
    .pc         (pc),
    .idx        (idx),
    .off        (off),
    .rs_val     (rs_val),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .target     (target),
    .misaligned (misaligned)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [1:0] m, input logic [31:0] p, input logic [25:0] i,
                       input logic [15:0] o, input logic [31:0] r);
    mode     = m;
    pc       = p;
    idx      = i;
    off      = o;
    rs_val   = r;
    in_valid = 1'b1;
  endtask

  // Single request with out_ready high: accepted at the next edge, visible right after.
  task automatic single(input string tag, input logic [1:0] m, input logic [31:0] p,
                        input logic [25:0] i, input logic [15:0] o, input logic [31:0] r,
                        input logic [31:0] exp_t, input logic exp_m);
    drive(m, p, i, o, r);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_target"}, 64'(target), 64'(exp_t));
    check({tag, "_mis"}, 64'(misaligned), 64'(exp_m));
  endtask

  initial begin
    logic [31:0] br_neg, br_pos;
`ifdef TAG_BRANCH_EN
    br_neg = 32'h0040_0000;
    br_pos = 32'h0040_0044;
`else
    br_neg = 32'h0040_0004;
    br_pos = 32'h0040_0004;
`endif
    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_target", 64'(target), 64'd0);
    check("rst_mis", 64'(misaligned), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    single("jump_lo",  2'b00, 32'h0040_0000, 26'h3FF_FFFD, 16'h0, 32'h0, 32'h0FFF_FFF4, 1'b0);
    single("jump_hi",  2'b00, 32'hF000_0000, 26'h3FF_FFFD, 16'h0, 32'h0, 32'hFFFF_FFF4, 1'b0);
    single("br_neg",   2'b01, 32'h0040_0000, 26'h0, 16'hFFFF, 32'h0, br_neg, 1'b0);
    single("br_pos",   2'b01, 32'h0040_0000, 26'h0, 16'h0010, 32'h0, br_pos, 1'b0);
    single("reg_mis",  2'b10, 32'h0, 26'h0, 16'h0, 32'h0040_0002, 32'h0040_0002, 1'b1);
    single("reg_ok",   2'b10, 32'h0, 26'h0, 16'h0, 32'h0040_0008, 32'h0040_0008, 1'b0);
    single("seq_wrap", 2'b11, 32'hFFFF_FFFC, 26'h0, 16'h0, 32'h0000_0003, 32'h0, 1'b0);
    @(negedge clk);
    check("idle_valid", 64'(out_valid), 64'd0);

    // Backpressure: A, B fill both entries, C must wait.
    out_ready = 1'b0;
    drive(2'b11, 32'h0000_0100, 26'h0, 16'h0, 32'h0);
    @(negedge clk);
    check("bp_a_ready", 64'(in_ready), 64'd1);
    check("bp_a_target", 64'(target), 64'h104);
    drive(2'b11, 32'h0000_0200, 26'h0, 16'h0, 32'h0);
    @(negedge clk);
    check("bp_b_ready", 64'(in_ready), 64'd0);
    check("bp_b_hold", 64'(target), 64'h104);
    drive(2'b11, 32'h0000_0300, 26'h0, 16'h0, 32'h0);
    @(negedge clk);
    check("bp_c_ready", 64'(in_ready), 64'd0);
    check("bp_c_hold", 64'(target), 64'h104);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_emit_b", 64'(target), 64'h204);
    check("bp_emit_b_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_emit_c", 64'(target), 64'h304);
    check("bp_emit_c_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("bp_drain", 64'(out_valid), 64'd0);

    // Flush with both entries full.
    out_ready = 1'b0;
    drive(2'b11, 32'h0000_1000, 26'h0, 16'h0, 32'h0);
    @(negedge clk);
    drive(2'b11, 32'h0000_2000, 26'h0, 16'h0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    check("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ready", 64'(in_ready), 64'd1);

    // Flush beats a simultaneous accept.
    drive(2'b11, 32'h0000_3000, 26'h0, 16'h0, 32'h0);
    flush = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_drop_valid", 64'(out_valid), 64'd0);
    check("fl_drop_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset mid-stream.
    drive(2'b00, 32'h0040_0000, 26'h3FF_FFFD, 16'h0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_target", 64'(target), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
